// File: rtl/byte_serial_add64_if.sv
// rtl/byte_serial_add64_if.sv - request/result bundle for the byte-serial 64-bit adder
//
// Purpose: groups the operand request and the result signals of byte_serial_add64.
// Signals:
//   start   request, sampled on clk while the adder is not running
//   a, b    operands, captured on the accepted start
//   c_in    carry into slice 0, captured on the accepted start
//   op_sub  subtract request (only honoured when BSA_SUB_EN is defined in the adder)
//   busy    high while the adder is running slices
//   done    one-cycle pulse when sum/c_out/ovf become valid
//   sum     result, held until the next completed operation
//   c_out   carry out of the MSB slice
//   ovf     signed overflow of the addition
// Modports: master drives requests (testbench / ALU control), slave is the adder.
interface byte_serial_add64_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              c_in;
    logic              op_sub;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] sum;
    logic              c_out;
    logic              ovf;

    modport master (
        output start, a, b, c_in, op_sub,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in, op_sub,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/byte_serial_add64.sv
// rtl/byte_serial_add64.sv - sequential 64-bit adder driving one 8-bit ripple slice per cycle
//
// Purpose: adds two DATA_W operands over N = DATA_W/SLICE_W cycles, LSB slice first,
// reusing a single rca8 slice with the carry registered between slices. The result,
// carry and signed overflow are published together in the single-cycle DONE state.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     byte_serial_add64_if.slave (start/a/b/c_in/op_sub in; busy/done/sum/c_out/ovf out)
// Configuration macro: BSA_SUB_EN - when defined, op_sub=1 at capture computes a-b
// (b inverted, initial carry forced to 1); when undefined op_sub is ignored.

module rca8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c_in,
    output logic [7:0] z,
    output logic       c_out
);
    assign {c_out, z} = {1'b0, x} + {1'b0, y} + {8'd0, c_in};
endmodule

module byte_serial_add64 #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    byte_serial_add64_if.slave        bus
);
    localparam int N     = DATA_W / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic              carry_r;
    // Operands are shifted right one slice per cycle so the slice always reads bits [7:0].
    logic [DATA_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;
    // Partial result: finished slices enter at the top and move down each cycle.
    logic [DATA_W-1:0] acc;
    logic              a_msb;
    logic              b_msb;
    logic [DATA_W-1:0] sum_r;
    logic              c_out_r;
    logic              ovf_r;

    logic              accept;
    logic              last;
    logic              busy_c;
    logic              done_c;

    logic [DATA_W-1:0] b_eff;
    logic              cin_eff;

    logic [SLICE_W-1:0] z;
    logic               co;

`ifdef BSA_SUB_EN
    assign b_eff   = bus.op_sub ? ~bus.b : bus.b;
    assign cin_eff = bus.op_sub ? 1'b1 : bus.c_in;
`else
    logic unused_op_sub;
    assign unused_op_sub = bus.op_sub;
    assign b_eff         = bus.b;
    assign cin_eff       = bus.c_in;
`endif

    rca8 u_slice (
        .x     (a_sh[SLICE_W-1:0]),
        .y     (b_sh[SLICE_W-1:0]),
        .c_in  (carry_r),
        .z     (z),
        .c_out (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt == CNT_W'(N - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            carry_r <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= b_eff;
            a_msb   <= bus.a[DATA_W-1];
            b_msb   <= b_eff[DATA_W-1];
            carry_r <= cin_eff;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> SLICE_W;
            b_sh    <= b_sh >> SLICE_W;
            acc     <= {z, acc[DATA_W-1:SLICE_W]};
            carry_r <= co;
            if (last) begin
                cnt     <= '0;
                // Outputs change only here, so partial slices are never visible.
                sum_r   <= {z, acc[DATA_W-1:SLICE_W]};
                c_out_r <= co;
                ovf_r   <= (a_msb == b_msb) && (z[SLICE_W-1] != a_msb);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
    assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_byte_serial_add64.sv
// tb/tb_byte_serial_add64.sv - directed self-checking bench for byte_serial_add64
module tb_byte_serial_add64;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    byte_serial_add64_if #(.DATA_W(64)) bif ();

    byte_serial_add64 #(.DATA_W(64), .SLICE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; returns cycles from the accepting edge.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc,
                          input logic ts, output int lat);
        @(negedge clk);
        bif.a      = ta;
        bif.b      = tb_v;
        bif.c_in   = tc;
        bif.op_sub = ts;
        bif.start  = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        lat = 0;
        while (!bif.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int lat;
    int pulses;
    logic [63:0] seen_sum;
    logic [63:0] pre_sum;

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        bif.start   = 1'b0;
        bif.a       = '0;
        bif.b       = '0;
        bif.c_in    = 1'b0;
        bif.op_sub  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bif.busy), 64'd0);
        check("reset_done", 64'(bif.done), 64'd0);
        check("reset_sum", bif.sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap: all ones + carry
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat);
        check("wrap_latency", 64'(lat), 64'd8);
        check("wrap_sum", bif.sum, 64'h0);
        check("wrap_cout", 64'(bif.c_out), 64'd1);
        check("wrap_ovf", 64'(bif.ovf), 64'd0);
        @(posedge clk);
        #1;
        check("wrap_done_one_cycle", 64'(bif.done), 64'd0);
        check("wrap_sum_held", bif.sum, 64'h0);

        // Cross-slice ripple
        run_op(64'h0000_0000_0000_00FF, 64'h1, 1'b0, 1'b0, lat);
        check("ripple_latency", 64'(lat), 64'd8);
        check("ripple_sum", bif.sum, 64'h100);
        check("ripple_cout", 64'(bif.c_out), 64'd0);

        // Signed overflow
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
        check("ovf_sum", bif.sum, 64'h8000_0000_0000_0000);
        check("ovf_flag", 64'(bif.ovf), 64'd1);
        check("ovf_cout", 64'(bif.c_out), 64'd0);

        // Mixed slices with carry chain through several bytes
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, lat);
        check("mixed_sum", bif.sum, 64'h2222_2222_2222_2212);
        check("mixed_cout", 64'(bif.c_out), 64'd0);

        // Start while busy: second start at RUN cycle 3 must be ignored
        @(negedge clk);
        bif.a     = 64'h0000_0000_0000_1000;
        bif.b     = 64'h0000_0000_0000_0234;
        bif.c_in  = 1'b0;
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        check("busy_after_start", 64'(bif.busy), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bif.a     = 64'd5;
        bif.b     = 64'd5;
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        pulses   = 0;
        seen_sum = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (bif.done) begin
                pulses++;
                seen_sum = bif.sum;
            end
        end
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_sum", seen_sum, 64'h1234);

        // Reset mid-run at RUN cycle 4
        @(negedge clk);
        bif.a     = 64'h0000_0000_0000_0003;
        bif.b     = 64'h0000_0000_0000_0004;
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        pre_sum = bif.sum;
        check("pre_reset_sum_nonzero", 64'(pre_sum != 64'h0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bif.busy), 64'd0);
        check("midrst_done", 64'(bif.done), 64'd0);
        check("midrst_sum", bif.sum, 64'd0);
        check("midrst_cout_ovf", {62'd0, bif.c_out, bif.ovf}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bif.done) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        run_op(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'd8);
        check("post_rst_sum", bif.sum, 64'd7);

        // Back-to-back: start held high gives one result every 9 cycles
        @(negedge clk);
        bif.a     = 64'd100;
        bif.b     = 64'd23;
        bif.c_in  = 1'b0;
        bif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.a = 64'h0000_0001_0000_0000;
        bif.b = 64'hFFFF_FFFF_0000_0000;
        lat = 0;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bif.done) begin
                pulses++;
                if (pulses == 1) begin
                    check("b2b_first_at", 64'(i), 64'd8);
                    check("b2b_first_sum", bif.sum, 64'd123);
                end else if (pulses == 2) begin
                    check("b2b_second_at", 64'(i), 64'd17);
                    check("b2b_second_sum", bif.sum, 64'h0);
                    check("b2b_second_cout", 64'(bif.c_out), 64'd1);
                    bif.start = 1'b0;
                end
            end
        end
        bif.start = 1'b0;
        check("b2b_pulses", 64'(pulses), 64'd2);
        repeat (12) @(posedge clk);

        // Subtract request: a=5, b=7, op_sub=1
        run_op(64'd5, 64'd7, 1'b0, 1'b1, lat);
`ifdef BSA_SUB_EN
        check("sub_sum", bif.sum, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        check("sub_sum", bif.sum, 64'hC);
`endif
        check("sub_cout", 64'(bif.c_out), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
